fpu_addsub_seq: RTL

Parametrised sequential floating-point adder/subtractor; next generation of the team's fixed 32-bit FPU.
- Generalised exponent/mantissa widths, add/sub mode select, start/done handshake, multi-cycle align/normalise FSM, one-hot status.
- Sits between the operand registers and the result bus of the FPU datapath.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_unpack.sv | 27 ++
 rtl/fpu_addsub_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared FSM states, status bit indices and exponent-bias helper
//             for the sequential FPU adder/subtractor.
//  Revision : 1.0  initial parametrised release
// ============================================================================
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_PACK  = 3'd4
  } fpu_state_e;

  localparam int c_st_exact     = 0;
  localparam int c_st_overflow  = 1;
  localparam int c_st_underflow = 2;
  localparam int c_st_inexact   = 3;

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_unpack
//  Purpose  : Splits a packed word into sign/exponent/significand; a zero
//             exponent forces the significand (including hidden bit) to 0.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic [EXP_W+MAN_W:0] word,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [MAN_W:0]       sig,
  output logic                 is_zero
);

  assign sign     = word[EXP_W+MAN_W];
  assign exponent = word[MAN_W +: EXP_W];
  assign is_zero  = (exponent == '0);
  assign sig      = is_zero ? '0 : {1'b1, word[MAN_W-1:0]};

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_addsub_seq
//  Purpose  : Multi-cycle floating-point add/subtract with start/done
//             handshake, bit-serial align/normalise and one-hot status.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                 clock100KHz,
  input  logic                 reset,
  input  logic                 start_in,
  input  logic                 op_sel_in,
  input  logic [EXP_W+MAN_W:0] op_A_in,
  input  logic [EXP_W+MAN_W:0] op_B_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [EXP_W+MAN_W:0] data_out,
  output logic [3:0]           status_out
);

  localparam int c_w     = 1 + EXP_W + MAN_W;
  localparam int c_sig_w = MAN_W + 3;  // carry, hidden, mantissa, guard
  localparam int c_e_w   = EXP_W + 1;
  localparam logic [c_e_w-1:0] c_exp_max = c_e_w'((2 ** EXP_W) - 2);

  fpu_state_e r_state, w_state_nxt;

  logic               w_a_sign, w_b_sign, w_a_zero, w_b_zero;
  logic [EXP_W-1:0]   w_a_exp, w_b_exp;
  logic [MAN_W:0]     w_a_sig, w_b_sig;
  logic               w_b_eff_sign, w_swap;
  logic               w_x_sign;
  logic [EXP_W-1:0]   w_x_exp, w_y_exp;
  logic [MAN_W:0]     w_x_sig, w_y_sig;

  logic               r_x_sign, r_sub, r_sticky, r_zero, r_uflow;
  logic [c_e_w-1:0]   r_x_exp;
  logic [c_sig_w-1:0] r_x_mag, r_y_mag;
  logic [EXP_W-1:0]   r_d;

  logic               w_align_far, w_align_last;
  logic               w_carry, w_hidden, w_mag_zero, w_exp_floor, w_norm_last;
  logic [c_w-1:0]     w_pack_data;
  logic [3:0]         w_pack_status;

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .word     (op_A_in),
    .sign     (w_a_sign),
    .exponent (w_a_exp),
    .sig      (w_a_sig),
    .is_zero  (w_a_zero)
  );

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .word     (op_B_in),
    .sign     (w_b_sign),
    .exponent (w_b_exp),
    .sig      (w_b_sig),
    .is_zero  (w_b_zero)
  );

  // Larger magnitude becomes X so subtraction never borrows out of the top.
  assign w_b_eff_sign = w_b_sign ^ op_sel_in;
  assign w_swap       = !w_b_zero &&
                        (w_a_zero || ({w_b_exp, w_b_sig} > {w_a_exp, w_a_sig}));
  assign w_x_sign     = w_swap ? w_b_eff_sign : w_a_sign;
  assign w_x_exp      = w_swap ? w_b_exp : w_a_exp;
  assign w_y_exp      = w_swap ? w_a_exp : w_b_exp;
  assign w_x_sig      = w_swap ? w_b_sig : w_a_sig;
  assign w_y_sig      = w_swap ? w_a_sig : w_b_sig;

  assign w_align_far  = int'(r_d) > (MAN_W + 2);
  assign w_align_last = w_align_far || (r_d <= EXP_W'(1));

  assign w_carry      = r_x_mag[c_sig_w-1];
  assign w_hidden     = r_x_mag[MAN_W+1];
  assign w_mag_zero   = (r_x_mag == '0);
  assign w_exp_floor  = (r_x_exp <= c_e_w'(1));
  // The left shift done this cycle lands r_x_mag[MAN_W] on the hidden bit.
  assign w_norm_last  = w_mag_zero || w_carry || w_hidden || w_exp_floor ||
                        r_x_mag[MAN_W];

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_state_nxt = S_ALIGN;
      S_ALIGN: if (w_align_last) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  if (w_norm_last) w_state_nxt = S_PACK;
      S_PACK:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out = (r_state != S_IDLE);
  end

  always_comb begin
    w_pack_data   = '0;
    w_pack_status = '0;
    if (r_zero) begin
      w_pack_status[r_sticky ? c_st_inexact : c_st_exact] = 1'b1;
    end else if (r_x_exp > c_exp_max) begin
      w_pack_data = {r_x_sign, c_exp_max[EXP_W-1:0], {MAN_W{1'b1}}};
      w_pack_status[c_st_overflow] = 1'b1;
    end else if (r_uflow) begin
      w_pack_status[c_st_underflow] = 1'b1;
    end else begin
      w_pack_data = {r_x_sign, r_x_exp[EXP_W-1:0], r_x_mag[MAN_W:1]};
      w_pack_status[(r_sticky || r_x_mag[0]) ? c_st_inexact : c_st_exact] = 1'b1;
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_x_sign   <= 1'b0;
      r_sub      <= 1'b0;
      r_sticky   <= 1'b0;
      r_zero     <= 1'b0;
      r_uflow    <= 1'b0;
      r_x_exp    <= '0;
      r_x_mag    <= '0;
      r_y_mag    <= '0;
      r_d        <= '0;
      done_out   <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_x_sign <= w_x_sign;
            r_sub    <= w_a_sign ^ w_b_eff_sign;
            r_x_exp  <= {1'b0, w_x_exp};
            r_x_mag  <= {1'b0, w_x_sig, 1'b0};
            r_y_mag  <= {1'b0, w_y_sig, 1'b0};
            r_d      <= w_x_exp - w_y_exp;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
            r_uflow  <= 1'b0;
          end
        end
        S_ALIGN: begin
          if (w_align_far) begin
            r_sticky <= r_sticky | (|r_y_mag);
            r_y_mag  <= '0;
            r_d      <= '0;
          end else if (r_d != '0) begin
            r_y_mag  <= r_y_mag >> 1;
            r_sticky <= r_sticky | r_y_mag[0];
            r_d      <= r_d - EXP_W'(1);
          end
        end
        S_ADD: begin
          r_x_mag <= r_sub ? (r_x_mag - r_y_mag) : (r_x_mag + r_y_mag);
        end
        S_NORM: begin
          if (w_mag_zero) begin
            r_zero <= 1'b1;
          end else if (w_carry) begin
            r_x_mag  <= r_x_mag >> 1;
            r_sticky <= r_sticky | r_x_mag[0];
            r_x_exp  <= r_x_exp + c_e_w'(1);
          end else if (!w_hidden) begin
            if (w_exp_floor) begin
              r_uflow <= 1'b1;
            end else begin
              r_x_mag <= r_x_mag << 1;
              r_x_exp <= r_x_exp - c_e_w'(1);
            end
          end
        end
        S_PACK: begin
          data_out   <= w_pack_data;
          status_out <= w_pack_status;
          done_out   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
